memcpy_sequencer: RTL

//  Multi-cycle controller for the memcpy instruction in the EX/MEM stages. Given src/dst byte

---
 rtl/memcpy_pkg.sv | 28 ++
 rtl/memcpy_sequencer_if.sv | 44 ++++
 rtl/memcpy_index_counter.sv | 61 ++++++
 rtl/memcpy_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/memcpy_pkg.sv
// Shared definitions for the memcpy sequencer.
// Contents:
//   memcpy_state_t     sequencer state encoding (IDLE, LOAD, STORE, DONE)
//   LS_BYTE/LS_WORD    data_memory load/store type encodings
//   STEP_BYTE/WORD     address increment per element
//   ls_type()          maps the element-size flag to a load/store type
package memcpy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } memcpy_state_t;

  // Same encodings the main decoder drives into data_memory.
  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  localparam int unsigned STEP_BYTE = 1;
  localparam int unsigned STEP_WORD = 4;

  function automatic logic [1:0] ls_type(input logic words);
    return words ? LS_WORD : LS_BYTE;
  endfunction

endpackage

// File: rtl/memcpy_sequencer_if.sv
// Bus between the pipeline/data_memory and the memcpy sequencer.
// Signals:
//   start, flush, words, src_base, dst_base, count_n  - command from EX
//   mem_read_data                                      - data_memory read data
//   mem_read, mem_write, mem_addr, mem_write_data,
//   load_store_type                                    - data_memory beat controls
//   stall, busy, done                                  - pipeline status
// Modports: master = pipeline/memory side, slave = sequencer.
interface memcpy_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int N_WIDTH    = 7
) ();

  logic                  start;
  logic                  flush;
  logic                  words;
  logic [ADDR_WIDTH-1:0] src_base;
  logic [ADDR_WIDTH-1:0] dst_base;
  logic [N_WIDTH-1:0]    count_n;
  logic [DATA_WIDTH-1:0] mem_read_data;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic [1:0]            load_store_type;
  logic                  stall;
  logic                  busy;
  logic                  done;

  modport master (
    output start, flush, words, src_base, dst_base, count_n, mem_read_data,
    input  mem_read, mem_write, mem_addr, mem_write_data, load_store_type,
           stall, busy, done
  );

  modport slave (
    input  start, flush, words, src_base, dst_base, count_n, mem_read_data,
    output mem_read, mem_write, mem_addr, mem_write_data, load_store_type,
           stall, busy, done
  );

endinterface

// File: rtl/memcpy_index_counter.sv
// Element index counter for the memcpy sequencer.
// Loads a start index and an end index, then steps up or down by one per
// advance. last_o flags that the current index is the final element.
// Ports:
//   clk, rstn      clock, asynchronous active-high reset
//   load_i         load start/end index and direction
//   load_index_i   first element index
//   load_last_i    final element index
//   load_down_i    1 = count down, 0 = count up
//   advance_i      move to the next element
//   index_o        current element index
//   last_o         current index equals the final index
module memcpy_index_counter #(
  parameter int N_WIDTH = 7
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               load_i,
  input  logic [N_WIDTH-1:0] load_index_i,
  input  logic [N_WIDTH-1:0] load_last_i,
  input  logic               load_down_i,
  input  logic               advance_i,
  output logic [N_WIDTH-1:0] index_o,
  output logic               last_o
);

  logic [N_WIDTH-1:0] index_q, index_d;
  logic [N_WIDTH-1:0] last_q, last_d;
  logic               down_q, down_d;

  always_comb begin
    index_d = index_q;
    last_d  = last_q;
    down_d  = down_q;
    if (load_i) begin
      index_d = load_index_i;
      last_d  = load_last_i;
      down_d  = load_down_i;
    end else if (advance_i) begin
      index_d = down_q ? index_q - 1'b1 : index_q + 1'b1;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      index_q <= '0;
      last_q  <= '0;
      down_q  <= 1'b0;
    end else begin
      index_q <= index_d;
      last_q  <= last_d;
      down_q  <= down_d;
    end
  end

  assign index_o = index_q;
  assign last_o  = (index_q == last_q);

endmodule

// File: rtl/memcpy_sequencer.sv
// memcpy controller for the EX/MEM stages. On start it latches the operands
// and drives data_memory as alternating load/store beats, one element per
// LOAD/STORE pair, stalling the pipeline until the DONE cycle.
// Ports:
//   clk    clock
//   rstn   asynchronous reset, active-high despite the name
//   bus    memcpy_sequencer_if.slave (command, data_memory beats, status)
// Build option: define MEMCPY_OVERLAP_EN to copy overlapping regions with
// dst above src in descending order (memmove semantics).
module memcpy_sequencer
  import memcpy_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int N_WIDTH    = 7
) (
  input logic               clk,
  input logic               rstn,
  memcpy_sequencer_if.slave bus
);

  memcpy_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic                  words_q;
  logic [DATA_WIDTH-1:0] buffer_q;

  logic                  accept;
  logic                  count_zero;
  logic                  descending;
  logic [N_WIDTH-1:0]    last_index;
  logic [N_WIDTH-1:0]    index;
  logic                  last;
  logic                  advance;
  logic [ADDR_WIDTH-1:0] offset;
  logic [DATA_WIDTH-1:0] store_data;

  // A start is taken only from IDLE and never in a flush cycle.
  assign accept     = (state_q == IDLE) && bus.start && !bus.flush;
  assign count_zero = (bus.count_n == '0);
  assign last_index = bus.count_n - 1'b1;

`ifdef MEMCPY_OVERLAP_EN
  logic [ADDR_WIDTH-1:0] step_in;
  logic [ADDR_WIDTH-1:0] span;

  assign step_in    = bus.words ? ADDR_WIDTH'(STEP_WORD) : ADDR_WIDTH'(STEP_BYTE);
  assign span       = ADDR_WIDTH'(bus.count_n) * step_in;
  // dst inside (src, src+span): an ascending copy would overwrite source
  // elements before they are read, so walk from the top element down.
  assign descending = (bus.src_base < bus.dst_base) &&
                      (bus.dst_base < bus.src_base + span);
`else
  assign descending = 1'b0;
`endif

  assign advance = (state_q == STORE) && !bus.flush && !last;

  memcpy_index_counter #(
    .N_WIDTH (N_WIDTH)
  ) u_index (
    .clk          (clk),
    .rstn         (rstn),
    .load_i       (accept && !count_zero),
    .load_index_i (descending ? last_index : '0),
    .load_last_i  (descending ? '0 : last_index),
    .load_down_i  (descending),
    .advance_i    (advance),
    .index_o      (index),
    .last_o       (last)
  );

  assign offset = ADDR_WIDTH'(index) *
                  (words_q ? ADDR_WIDTH'(STEP_WORD) : ADDR_WIDTH'(STEP_BYTE));

  // Byte elements store only the loaded byte; data_memory masks the lane.
  assign store_data = words_q ? buffer_q : DATA_WIDTH'(buffer_q[7:0]);

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.start) state_d = count_zero ? DONE : LOAD;
        LOAD:    state_d = STORE;
        STORE:   state_d = last ? DONE : LOAD;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_addr        = '0;
    bus.mem_write_data  = '0;
    bus.stall           = 1'b0;
    bus.done            = 1'b0;
    bus.busy            = (state_q != IDLE);
    bus.load_store_type = ls_type(words_q);
    case (state_q)
      // Stall already in the start cycle; held low while reset is applied.
      IDLE:  bus.stall = bus.start && !rstn;
      LOAD: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = src_q + offset;
        bus.stall    = 1'b1;
      end
      STORE: begin
        bus.mem_write      = !bus.flush;
        bus.mem_addr       = dst_q + offset;
        bus.mem_write_data = store_data;
        bus.stall          = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      src_q    <= '0;
      dst_q    <= '0;
      words_q  <= 1'b0;
      buffer_q <= '0;
    end else begin
      if (accept) begin
        src_q   <= bus.src_base;
        dst_q   <= bus.dst_base;
        words_q <= bus.words;
      end
      if (state_q == LOAD) buffer_q <= bus.mem_read_data;
    end
  end

endmodule
